// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin scheduler for the shared common data bus.
// Each producer owns a one-entry holding slot; one occupied slot is broadcast (registered) per cycle.
module cdb_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ID_WIDTH  = 4,
    parameter int VAL_WIDTH = 32,
    parameter int SRC_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush_in,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ID_WIDTH-1:0]  req_tag,
    input  logic [NUM_REQ*VAL_WIDTH-1:0] req_val,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         cdb_valid,
    output logic [ID_WIDTH-1:0]          cdb_tag,
    output logic [VAL_WIDTH-1:0]         cdb_val,
    output logic [SRC_WIDTH-1:0]         cdb_src,
    output logic                         busy
);

    logic [NUM_REQ-1:0]   occ;
    logic [ID_WIDTH-1:0]  slot_tag [NUM_REQ];
    logic [VAL_WIDTH-1:0] slot_val [NUM_REQ];
    logic [SRC_WIDTH-1:0] rr_ptr;

    logic                 active;
    logic [SRC_WIDTH-1:0] cand [NUM_REQ];
    logic                 win_found;
    logic [SRC_WIDTH-1:0] win_idx;
    logic                 grant;
    logic [SRC_WIDTH-1:0] next_ptr;

    assign active = rdy_in & ~flush_in;

    // cand[k] is the slot examined k-th in priority order, starting at rr_ptr.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            cand[k] = SRC_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && occ[cand[k]]) begin
                win_found = 1'b1;
                win_idx   = cand[k];
            end
        end
    end

    assign grant    = win_found & active;
    assign next_ptr = (win_idx == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + SRC_WIDTH'(1);
    assign busy     = |occ;

    // Handshake: a slot takes {tag,val} at the edge where req_valid[i] & req_ready[i];
    // the producer holds tag/val stable while valid and not ready, and drops offers made during a flush.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = rst_in & active & (~occ[i] | (grant & (win_idx == SRC_WIDTH'(i))));
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            occ       <= '0;
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_val   <= '0;
            cdb_src   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_tag[i] <= '0;
                slot_val[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                occ       <= '0;
                rr_ptr    <= '0;
                cdb_valid <= 1'b0;
            end else begin
                cdb_valid <= grant;
                if (grant) begin
                    cdb_tag      <= slot_tag[win_idx];
                    cdb_val      <= slot_val[win_idx];
                    cdb_src      <= win_idx;
                    occ[win_idx] <= 1'b0;
                    rr_ptr       <= next_ptr;
                end
                // A refill of the slot being granted overrides the clear above.
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        occ[i]      <= 1'b1;
                        slot_tag[i] <= req_tag[i*ID_WIDTH +: ID_WIDTH];
                        slot_val[i] <= req_val[i*VAL_WIDTH +: VAL_WIDTH];
                    end
                end
            end
        end
    end

endmodule
